// File: rtl/darkdebugmon_pkg.sv
// Shared types and constants for the debug-bus monitor: snapshot layout,
// frame format and serializer states.
package darkdebugmon_pkg;

  localparam int         FRAME_WORDS = 6;
  localparam logic [7:0] HDR_MAGIC   = 8'hA5;
  localparam logic [2:0] LAST_IDX    = 3'(FRAME_WORDS - 1);

  // One captured change of the observed buses.
  typedef struct packed {
    logic [15:0]       seq;
    logic [31:0]       ts;
    logic [3:0]        led;
    logic [3:0][31:0]  debug;
  } snap_t;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  // Word idx of the 6-word frame that carries snapshot s.
  function automatic logic [31:0] frame_word(input snap_t s, input logic [2:0] idx);
    logic [31:0] w;
    case (idx)
      3'd0:    w = {HDR_MAGIC, 4'h0, s.led, s.seq};
      3'd1:    w = s.ts;
      3'd2:    w = s.debug[0];
      3'd3:    w = s.debug[1];
      3'd4:    w = s.debug[2];
      3'd5:    w = s.debug[3];
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/darkdebugmon_darkfifo.sv
// Generic synchronous FIFO. Pointers carry one extra wrap bit so full and
// empty are distinguishable; a push while full is accepted when a pop
// happens in the same cycle. Head and the entry behind it are exposed so the
// consumer can look one entry ahead.
module darkfifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     XCLK,
  input  logic                     XRES,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [WIDTH-1:0]         o_head,
  output logic [WIDTH-1:0]         o_second
);

  localparam int        AW  = $clog2(DEPTH);
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic [AW:0]      w_count;
  logic             w_do_push;
  logic             w_do_pop;
  logic [AW-1:0]    w_rd_nxt;

  // Occupancy, qualified push/pop and read ports.
  always_comb begin
    w_count   = r_wr - r_rd;
    o_count   = w_count;
    o_full    = (w_count == CAP);
    o_empty   = (w_count == '0);
    w_do_pop  = i_pop && !o_empty;
    w_do_push = i_push && (!o_full || w_do_pop);
    w_rd_nxt  = r_rd[AW-1:0] + 1'b1;
    o_head    = r_mem[r_rd[AW-1:0]];
    o_second  = r_mem[w_rd_nxt];
  end

  // Read/write pointers.
  always_ff @(posedge XCLK or negedge XRES) begin
    if (!XRES) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  // Storage array.
  // NOTE: the storage is deliberately not reset; the pointers alone define
  // which entries are valid, and an unreset array maps onto plain RAM.
  always_ff @(posedge XCLK) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/darkdebugmon.sv
// Debug-bus monitor: detects changes on {LED, DEBUG}, timestamps and
// sequence-numbers them into a snapshot FIFO, and serializes each snapshot
// as a 6-word frame on a valid/ready stream. Lost snapshots are counted.
module darkdebugmon #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] TS_RESET = 32'h0  // timestamp reset value; 0 in normal use
) (
  input  logic             XCLK,
  input  logic             XRES,
  input  logic             EN,
  input  logic [3:0]       LED,
  input  logic [3:0][31:0] DEBUG,
  output logic             OUT_VALID,
  output logic [31:0]      OUT_DATA,
  output logic             OUT_LAST,
  input  logic             OUT_READY,
  output logic             FULL,
  output logic [15:0]      DROPS
);

  import darkdebugmon_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [131:0] r_prev;
  logic [31:0]  r_ts;
  logic [15:0]  r_seq;
  logic [15:0]  r_drops;
  state_t       r_state;
  logic [2:0]   r_idx;
  logic         r_valid;
  logic [31:0]  r_data;
  logic         r_last;

  logic [131:0] w_cur;
  logic         w_chg;
  logic         w_accept;
  logic         w_pop;
  logic         w_push;
  logic         w_drop;
  logic         w_more;
  logic [2:0]   w_idx_nxt;
  snap_t        w_snap;
  snap_t        w_head;
  snap_t        w_second;
  snap_t        w_next;
  logic         w_full;
  logic         w_empty;
  logic [AW:0]  w_count;

  darkfifo #(
    .WIDTH ($bits(snap_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .XCLK     (XCLK),
    .XRES     (XRES),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_wdata  (w_snap),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_count  (w_count),
    .o_head   (w_head),
    .o_second (w_second)
  );

  // Change detection, push/drop decision and next-frame lookahead.
  // NOTE: every signal gets a value on every path through this block, so no
  // latch can be inferred.
  always_comb begin
    w_cur       = {LED, DEBUG};
    w_chg       = EN && (w_cur != r_prev);
    w_accept    = r_valid && OUT_READY;
    w_pop       = w_accept && (r_idx == LAST_IDX);
    // A same-cycle pop frees the slot this push needs.
    w_push      = w_chg && (!w_full || w_pop);
    w_drop      = w_chg && w_full && !w_pop;
    w_idx_nxt   = r_idx + 3'd1;
    w_snap.seq   = r_seq;
    w_snap.ts    = r_ts;
    w_snap.led   = LED;
    w_snap.debug = DEBUG;
    // After popping the head, the next frame comes from the second entry, or
    // from the snapshot being written this very cycle if it was the only one.
    w_more      = (w_count > (AW+1)'(1)) || w_push;
    w_next      = (w_count > (AW+1)'(1)) ? w_second : w_snap;
  end

  // Free-running timestamp.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of its inputs.
  always_ff @(posedge XCLK or negedge XRES) begin
    if (!XRES) r_ts <= TS_RESET;
    else       r_ts <= r_ts + 32'd1;
  end

  // Last-seen value, sequence number and saturating drop counter.
  always_ff @(posedge XCLK or negedge XRES) begin
    if (!XRES) begin
      r_prev  <= '0;
      r_seq   <= '0;
      r_drops <= '0;
    end else begin
      if (w_chg)  r_prev <= w_cur;
      if (w_push) r_seq  <= r_seq + 16'd1;
      if (w_drop && (r_drops != 16'hFFFF)) r_drops <= r_drops + 16'd1;
    end
  end

  // Serializer FSM with registered stream outputs.
  always_ff @(posedge XCLK or negedge XRES) begin
    if (!XRES) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_state <= SEND;
            r_idx   <= '0;
            r_valid <= 1'b1;
            r_data  <= frame_word(w_head, 3'd0);
            r_last  <= 1'b0;
          end
        end
        SEND: begin
          if (w_accept) begin
            if (r_idx == LAST_IDX) begin
              r_idx  <= '0;
              r_last <= 1'b0;
              if (w_more) begin
                r_data <= frame_word(w_next, 3'd0);
              end else begin
                r_state <= IDLE;
                r_valid <= 1'b0;
                r_data  <= '0;
              end
            end else begin
              r_idx  <= w_idx_nxt;
              r_data <= frame_word(w_head, w_idx_nxt);
              r_last <= (w_idx_nxt == LAST_IDX);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign OUT_VALID = r_valid;
  assign OUT_DATA  = r_data;
  assign OUT_LAST  = r_last;
  assign FULL      = w_full;
  assign DROPS     = r_drops;

endmodule

// File: tb/tb_darkdebugmon.sv
// Self-checking bench for darkdebugmon. Stimulus is driven 2 time units after
// each rising edge; a negedge monitor predicts the next edge from a
// snapshot-level model (occupancy, seq, ts, drops) and keeps a queue of
// expected frame words that is compared whenever a word is accepted.
module tb_darkdebugmon;

  localparam int DEPTH = 4;
  localparam int FRAME = 6;

  logic             XCLK = 1'b0;
  logic             XRES = 1'b0;
  logic             EN = 1'b1;
  logic [3:0]       LED = '0;
  logic [3:0][31:0] DEBUG = '0;
  logic             OUT_READY = 1'b1;
  logic             OUT_VALID;
  logic [31:0]      OUT_DATA;
  logic             OUT_LAST;
  logic             FULL;
  logic [15:0]      DROPS;

  // Second instance, timestamp preset just below wrap.
  logic [3:0]       w_led = '0;
  logic [3:0][31:0] w_dbg = '0;
  logic             w_valid;
  logic [31:0]      w_data;
  logic             w_last;
  logic             w_full;
  logic [15:0]      w_drops;

  always #5 XCLK = ~XCLK;

  darkdebugmon #(.DEPTH(DEPTH)) dut (
    .XCLK(XCLK), .XRES(XRES), .EN(EN), .LED(LED), .DEBUG(DEBUG),
    .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA), .OUT_LAST(OUT_LAST),
    .OUT_READY(OUT_READY), .FULL(FULL), .DROPS(DROPS)
  );

  darkdebugmon #(.DEPTH(DEPTH), .TS_RESET(32'hFFFF_FFFD)) dut_w (
    .XCLK(XCLK), .XRES(XRES), .EN(1'b1), .LED(w_led), .DEBUG(w_dbg),
    .OUT_VALID(w_valid), .OUT_DATA(w_data), .OUT_LAST(w_last),
    .OUT_READY(1'b1), .FULL(w_full), .DROPS(w_drops)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [32:0]  sb[$];          // {last, data} expected words in order
  int           m_occ    = 0;   // snapshots held
  int           m_words  = 0;   // words of current frame already accepted
  int           m_frames = 0;   // frames fully delivered
  logic [131:0] m_prev   = '0;
  logic [31:0]  m_ts     = '0;
  logic [15:0]  m_seq    = '0;
  logic [15:0]  m_drops  = '0;
  logic         stall_prev = 1'b0;
  logic [32:0]  stall_val  = '0;

  always @(negedge XCLK) begin : monitor
    logic        pop;
    logic [32:0] exp_w;
    if (!XRES) begin
      sb.delete();
      m_occ = 0; m_words = 0; m_prev = '0; m_ts = '0;
      m_seq = '0; m_drops = '0; stall_prev = 1'b0;
    end else begin
      check("full_flag", FULL, (m_occ == DEPTH));
      check("drops", DROPS, m_drops);
      if (stall_prev) check("stall_hold", {OUT_VALID, OUT_LAST, OUT_DATA}, {1'b1, stall_val});
      if (m_words != 0) check("valid_mid_frame", OUT_VALID, 1);
      if (sb.size() == 0) check("spurious_valid", OUT_VALID, 0);
      pop = 1'b0;
      if (OUT_VALID && OUT_READY && sb.size() != 0) begin
        exp_w = sb.pop_front();
        check("word", {OUT_LAST, OUT_DATA}, exp_w);
        m_words++;
        if (m_words == FRAME) begin
          m_words = 0;
          m_frames++;
          pop = 1'b1;
        end
      end
      if (pop) m_occ--;
      if (EN && ({LED, DEBUG} != m_prev)) begin
        m_prev = {LED, DEBUG};
        if (m_occ < DEPTH) begin
          m_occ++;
          sb.push_back({1'b0, 8'hA5, 4'h0, LED, m_seq});
          sb.push_back({1'b0, m_ts});
          for (int j = 0; j < 4; j++) sb.push_back({(j == 3), DEBUG[j]});
          m_seq++;
        end else if (m_drops != 16'hFFFF) begin
          m_drops++;
        end
      end
      m_ts++;
      stall_prev = OUT_VALID && !OUT_READY;
      stall_val  = {OUT_LAST, OUT_DATA};
    end
  end

  // ---------------- stimulus helpers ----------------
  int ready_mode = 0;   // 0 high, 1 pattern 1,0,0, 2 random, 3 low
  int rdy_cnt    = 0;

  task automatic step();
    @(posedge XCLK);
    #2;
    rdy_cnt++;
    case (ready_mode)
      0:       OUT_READY = 1'b1;
      1:       OUT_READY = ((rdy_cnt % 3) == 0);
      2:       OUT_READY = 1'($urandom_range(0, 1));
      default: OUT_READY = 1'b0;
    endcase
  endtask

  task automatic do_reset();
    XRES = 1'b0;
    step();
    step();
    XRES = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0 && !OUT_VALID) break;
      step();
    end
    check("drain_pending", sb.size(), 0);
    check("drain_valid", OUT_VALID, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int          f0;
    int          cnt;
    logic        found;
    logic [31:0] words [FRAME];
    logic        last5;

    // Reset release with a non-zero input: exactly one frame.
    LED = 4'h3; DEBUG = '0; EN = 1'b1; ready_mode = 0;
    step(); step();
    XRES = 1'b1;
    step();
    check("lat_idle", OUT_VALID, 0);
    step();
    check("lat_valid", OUT_VALID, 1);
    check("rst_w0", OUT_DATA, 32'hA503_0000);
    check("rst_w0_last", OUT_LAST, 0);
    wait_drain(50);
    f0 = m_frames;
    repeat (20) step();
    check("rst_one_frame", m_frames, 1);
    check("rst_quiet", m_frames - f0, 0);

    // Backpressure with READY 1,0,0,...
    f0 = m_frames;
    ready_mode = 1;
    LED = 4'hA;
    for (int j = 0; j < 4; j++) DEBUG[j] = $urandom;
    step();
    wait_drain(200);
    check("bp_frames", m_frames - f0, 1);

    // Randomized changes, enable and backpressure.
    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        LED = 4'($urandom);
        DEBUG[$urandom_range(0, 3)] = $urandom;
      end
      EN = ($urandom_range(0, 7) != 0);
      step();
    end
    EN = 1'b1;
    ready_mode = 0;
    step();
    wait_drain(600);

    // Overflow: DEPTH+3 changes with the sink stalled.
    ready_mode = 3;
    LED = '0; DEBUG = '0;
    do_reset();
    f0 = m_frames;
    for (int i = 0; i < DEPTH + 3; i++) begin
      LED = 4'(i + 1);
      DEBUG[0] = $urandom;
      step();
    end
    check("ovf_full", FULL, 1);
    check("ovf_drops", DROPS, 3);
    check("ovf_valid", OUT_VALID, 1);

    // Full + pop collision: change lands on the w5 accept edge.
    ready_mode = 0;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (OUT_VALID && OUT_LAST) begin
        found = 1'b1;
        break;
      end
    end
    check("coll_found_w5", found, 1);
    LED = 4'hE;
    DEBUG[1] = $urandom;
    step();
    check("coll_full", FULL, 1);
    check("coll_drops", DROPS, 3);
    wait_drain(300);
    check("coll_frames", m_frames - f0, DEPTH + 1);

    // Enable gating: no frames while EN=0, one frame on raising EN.
    f0 = m_frames;
    EN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      LED = 4'(i + 1);
      DEBUG[2] = $urandom;
      step();
    end
    repeat (10) step();
    check("en_off_frames", m_frames - f0, 0);
    EN = 1'b1;
    step();
    wait_drain(100);
    check("en_on_frames", m_frames - f0, 1);

    // Reset during w3.
    LED = 4'h9;
    DEBUG[3] = $urandom;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (OUT_VALID && m_words == 3) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_w3_found", found, 1);
    XRES = 1'b0;
    #1;
    check("arst_valid", OUT_VALID, 0);
    check("arst_data", OUT_DATA, 0);
    check("arst_last", OUT_LAST, 0);
    check("arst_full", FULL, 0);
    check("arst_drops", DROPS, 0);
    LED = '0; DEBUG = '0;
    step(); step();
    XRES = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (OUT_VALID) cnt++;
    end
    check("arst_no_stale", cnt, 0);

    // Timestamp wrap on the preset instance: capture at edge 3 sees ts=0.
    w_led = '0;
    do_reset();
    step(); step(); step();
    w_led = 4'h5;
    cnt = 0;
    last5 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (w_valid) begin
        if (cnt < FRAME) words[cnt] = w_data;
        if (cnt == FRAME - 1) last5 = w_last;
        cnt++;
      end
    end
    check("wrap_count", cnt, FRAME);
    check("wrap_w0", words[0], 32'hA505_0000);
    check("wrap_w1_ts", words[1], 32'h0);
    check("wrap_w5_last", last5, 1);
    check("wrap_full", w_full, 0);
    check("wrap_drops", w_drops, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/darkdebugmon.md
# darkdebugmon

Debug-bus monitor: the receiving end of the SoC's `LED`/`DEBUG` observation outputs. Each cycle it compares the current `{LED, DEBUG}` against the last seen value. Every change is pushed, with a free-running timestamp and a sequence number, into a small snapshot FIFO. A serializer drains the FIFO as 6-word frames over a valid/ready stream. It sits beside `darksocv` in simulation or on the board as a lossy-but-accounted trace tap.

## Interface
- `DEPTH`, 4: snapshot FIFO entries; power of two, at least 2.
- `XCLK`  in  1  single clock; all state on its rising edge.
- `XRES`  in  1  asynchronous, active-low reset.
- `EN`  in  1  capture enable; when 0, no change detection, no pushes and `prev` holds.
- `LED`  in  4  observed LED bus.
- `DEBUG`  in  4x32  observed debug words `[3:0][31:0]`.
- `OUT_VALID`  out  1  frame word valid.
- `OUT_DATA`  out  32  frame word.
- `OUT_LAST`  out  1  high on the final (6th) word of a frame.
- `OUT_READY`  in  1  sink accepts the word when high together with `OUT_VALID`.
- `FULL`  out  1  FIFO occupancy == `DEPTH`.
- `DROPS`  out  16  count of snapshots lost to a full FIFO; saturates at 0xFFFF.

## Operation
- **Reset values.** `prev`=0, `ts`=0, `seq`=0, FIFO empty, FSM IDLE, `OUT_VALID`=0, `OUT_LAST`=0, `OUT_DATA`=0, `FULL`=0, `DROPS`=0.
- **Timestamp.** `ts` is a 32-bit counter, +1 every cycle, wraps 0xFFFFFFFF→0.
- **Change detect.** `chg` = `EN` & (`{LED,DEBUG}` != `prev`).
  - On `chg`, `prev` <= `{LED,DEBUG}` unconditionally.
  - The first non-zero input after reset produces a frame.
- **Push.** On `chg` with FIFO not full, write `{seq, ts, LED, DEBUG}` and increment `seq` (16-bit, wraps).
- **Drop.** On `chg` with FIFO full, do not write; `DROPS`++ (saturating); `seq` is unchanged.
- **Frame layout (6 words).**
  - w0 = `{8'hA5, 4'h0, LED, seq}`
  - w1 = `ts`
  - w2..w5 = `DEBUG[0]`..`DEBUG[3]`
- **FSM.**
  - IDLE: go to SEND (idx=0) when the FIFO is non-empty.
  - SEND: `OUT_VALID`=1 and `OUT_DATA`=word[idx]. On accept, idx++.
  - On accept with idx=5: pop the head entry. Then go to SEND idx=0 if more entries remain after the pop, otherwise IDLE.
  - The frame is read from the FIFO head; the head is not popped until w5 is accepted.
- **Handshake.**
  - `OUT_DATA`/`OUT_LAST` stay stable while `OUT_VALID` & !`OUT_READY`.
  - `OUT_VALID` never drops mid-frame except on reset.
  - `OUT_READY` may toggle arbitrarily.
- **Simultaneous push and pop.** Fullness for a push is judged after the same-cycle pop. A push when full, in the cycle w5 is accepted, succeeds; occupancy stays `DEPTH` and `DROPS` is unchanged.
- **Mid-operation reset.** Asserting `XRES` abandons any partial frame; all state returns to reset values asynchronously.

## Timing
- Input change sampled at edge k → FIFO written at edge k.
- If the FIFO was empty and the FSM IDLE: FSM enters SEND at edge k+1, and w0 is valid after edge k+1. Change-to-`OUT_VALID` latency is 2 cycles.
- With `OUT_READY` held high, a frame takes 6 cycles. Back-to-back frames have no idle cycle.
- Sustained throughput: one snapshot per 6 cycles. Faster change rates fill the FIFO, then drop.
- `FULL` and `DROPS` are registered and reflect the state after each edge.

## Structure
- Package `darkdebugmon_pkg`:
  - `FRAME_WORDS`=6, `HDR_MAGIC`=8'hA5.
  - `snap_t` struct `{seq[15:0], ts[31:0], led[3:0], debug[3:0][31:0]}`.
  - FSM enum `{IDLE, SEND}`.
- Sub-module `darkfifo`: a generic synchronous FIFO parameterized on width/depth.
  - Ports: push/pop/full/empty/head.
  - Same `XCLK`/`XRES` convention.
  - Simultaneous push+pop is legal when full.
- Top level holds change detect, counters, and the serializer FSM.

## Test plan
- **Reset release.** Inputs held at `LED`=4'h3, `DEBUG`=all 0, `EN`=1, `OUT_READY`=1 → exactly one frame: w0=0xA5030000, then w1=ts of the capture cycle, then w2..w5=0, with `OUT_LAST` only on w5. Nothing further while inputs are stable.
- **Backpressure.** One change, `OUT_READY` toggling 1,0,0,1,... → all 6 words delivered in order, `OUT_DATA` unchanged during stalls, `OUT_LAST` only on w5.
- **Overflow.** `OUT_READY`=0 and `DEPTH`+3 distinct changes on consecutive cycles → `FULL`=1, `DROPS`=3. Releasing `OUT_READY` yields `DEPTH` frames with seq 0..`DEPTH`-1.
- **Full + pop collision.** Hold the FIFO full, present a change in the same cycle w5 is accepted → no drop (`DROPS` unchanged), new entry framed later with the next seq.
- **Enable, wrap, and reset.**
  - `EN`=0 while inputs change → no frames, `prev` held; raising `EN` produces one frame.
  - Force `ts` near 0xFFFFFFFF → w1 wraps to 0.
  - Assert `XRES` during w3 → all outputs return to reset values immediately, and no stale frame appears after release.
